decoder_stream: RTL and testbench

Streaming binary-to-one-hot decoder, the inverse of the team's 4:2 encoder. Accepts W-bit binary codes over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Each code is presented as a registered 2^W-bit one-hot word over a second valid/ready handshake. It sits between a code producer (for example encoder output carried across a pipeline) and one-hot select/enable consumers that may stall.

---
 rtl/decoder_stream.sv | 64 ++++++
 tb/tb_decoder_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream.sv
// decoder_stream: FIFO-buffered binary-to-one-hot decoder with valid/ready on both sides
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i sync clear;
//   in_valid_i/in_ready_o/in_code_i producer side; out_valid_o/out_ready_i/out_onehot_o
//   consumer side (registered one-hot); level_o FIFO occupancy excluding output stage.
module decoder_stream #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [W-1:0]                 in_code_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [(1<<W)-1:0]            out_onehot_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int N  = 1 << W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic          push, load;
  always_comb begin
    in_ready_o = count_q != LW'(DEPTH) && !flush_i;
    push       = in_valid_i && in_ready_o;
    // the stage refills whenever it is empty or its word leaves this edge
    load       = !flush_i && count_q != '0 && (state_q == S_EMPTY || out_ready_i);
    wr_ptr_d   = flush_i ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d   = flush_i ? '0 : rd_ptr_q + AW'(load);
    count_d    = flush_i ? '0 : count_q + LW'(push) - LW'(load);
    state_d    = load ? S_FULL : (flush_i || out_ready_i) ? S_EMPTY : state_q;
    // word is cleared whenever the stage goes empty so out_onehot is zero when invalid
    onehot_d   = load ? N'(1) << mem_q[rd_ptr_q] : state_d == S_FULL ? onehot_q : '0;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_code_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_EMPTY;
      onehot_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      onehot_q <= onehot_d;
    end
  end
  assign out_valid_o  = state_q == S_FULL;
  assign out_onehot_o = onehot_q;
  assign level_o      = count_q;
endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream: directed self-checking bench for decoder_stream (W=2, DEPTH=4)
module tb_decoder_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_onehot;
  logic [2:0] level;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q [$];

  decoder_stream #(.W(2), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_code_i(in_code), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_onehot_o(out_onehot), .level_o(level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot got %b want 0000", out_onehot); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [3:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code = 2'(i);
      tick();
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d] got %0d want 1", i, level); end
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got %b want 0", out_valid); end
      end else begin
        exp = 4'b0001 << (i - 1);
        checks++; if (out_onehot !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL stream_oh[%0d] got %b/%b want %b/1", i, out_onehot, out_valid, exp); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_onehot !== 4'b1000 || level !== 3'd0) begin errors++; $display("FAIL stream_last got %b lvl %0d want 1000 lvl 0", out_onehot, level); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_onehot !== 4'b0000) begin errors++; $display("FAIL stream_empty got %b/%b want 0/0000", out_valid, out_onehot); end
  endtask

  task automatic test_backpressure();
    logic [1:0] codes [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [1:0] drain [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [3:0] exp;
    int acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_code = codes[i];
      #1;
      if (in_ready) acc++;
      tick();
      if (i > 0) begin
        checks++; if (out_onehot !== 4'b1000) begin errors++; $display("FAIL bp_hold[%0d] got %b want 1000", i, out_onehot); end
      end
    end
    in_valid = 1'b0;
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d want 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp = 4'b0001 << drain[j];
      checks++; if (out_valid !== 1'b1 || out_onehot !== exp) begin errors++; $display("FAIL bp_drain[%0d] got %b/%b want 1/%b", j, out_valid, out_onehot, exp); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] fill [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] drain [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [3:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code = fill[i];
      tick();
    end
    in_code = 2'd3;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fpp_ready_full got %b want 0", in_ready); end
    tick();
    checks++; if (level !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL fpp_pop got lvl %0d rdy %b want 3/1", level, in_ready); end
    out_ready = 1'b0;
    in_code = 2'd2;
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_push got %0d want 4", level); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp = 4'b0001 << drain[j];
      checks++; if (out_valid !== 1'b1 || out_onehot !== exp) begin errors++; $display("FAIL fpp_drain[%0d] got %b/%b want 1/%b", j, out_valid, out_onehot, exp); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [1:0] codes [12] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [3:0] exp;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    exp_q.delete();
    while (recv < 12 && cyc < 300) begin
      in_valid = sent < 12;
      in_code = codes[sent % 12];
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid) begin
        checks++; if (!$onehot(out_onehot)) begin errors++; $display("FAIL wrap_onehot got %b want one-hot", out_onehot); end
      end
      if (out_valid && out_ready) begin
        exp = exp_q.size() > 0 ? 4'b0001 << exp_q.pop_front() : 4'b0000;
        checks++; if (out_onehot !== exp) begin errors++; $display("FAIL wrap_order[%0d] got %b want %b", recv, out_onehot, exp); end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_code);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (recv != 12) begin errors++; $display("FAIL wrap_count got %0d want 12", recv); end
  endtask

  task automatic test_flush();
    logic [1:0] fill [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code = fill[i];
      tick();
    end
    checks++; if (level !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup got lvl %0d v %b want 3/1", level, out_valid); end
    flush = 1'b1;
    in_code = 2'd3;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0 || out_onehot !== 4'b0000) begin errors++; $display("FAIL flush_clear got lvl %0d v %b oh %b want 0/0/0000", level, out_valid, out_onehot); end
    tick();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL flush_not_stored got v %b lvl %0d want 0/0", out_valid, level); end
  endtask

  task automatic test_async_reset();
    logic [1:0] fill [3] = '{2'd0, 2'd3, 2'd1};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code = fill[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (level !== 3'd2 || out_onehot !== 4'b0001) begin errors++; $display("FAIL arst_setup got lvl %0d oh %b want 2/0001", level, out_onehot); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || level !== 3'd0) begin errors++; $display("FAIL arst_async got v %b oh %b lvl %0d want 0/0000/0", out_valid, out_onehot, level); end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_code = 2'd2;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_latency got %b want 0", out_valid); end
    tick();
    checks++; if (out_onehot !== 4'b0100 || out_valid !== 1'b1) begin errors++; $display("FAIL arst_push got %b/%b want 0100/1", out_onehot, out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
